hummingbird_ctrl: RTL

Iterative Hummingbird-2 encryption controller. It captures a 128-bit key, 64-bit IV and 128-bit plaintext block on a start handshake, then time-multiplexes one shared 16-bit word-step datapath:

- four initialization rounds, then
- eight word encryptions.

The 128-bit ciphertext is returned with a one-cycle done pulse. It replaces eight parallel word-encryption instances with one, and supports chained messages that reuse the internal state without re-initialization.

---
 rtl/hb2_pkg.sv | 52 +++++
 rtl/hummingbird_ctrl_if.sv | 33 +++
 rtl/hb2_word_step.sv | 93 +++++++++
 rtl/hummingbird_ctrl.sv | 123 ++++++++++++
 4 files changed

// File: rtl/hb2_pkg.sv
// -----------------------------------------------------------------------------
// hb2_pkg
// Shared types and constants for the Hummingbird-2 encryption controller:
// word/counter widths, the FSM state and step-mode encodings, the packed
// types for key, IV, 128-bit block and the R1..R8 register set, the
// IV-round constants, and the IV-to-register-set expansion.
// -----------------------------------------------------------------------------
package hb2_pkg;

    localparam int WORD_W      = 16;   // fixed by the algorithm
    localparam int INIT_ROUNDS = 4;
    localparam int WORDS       = 8;
    localparam int CNT_W       = 3;
    localparam int RND_W       = $clog2(INIT_ROUNDS);

    typedef logic [WORD_W-1:0] word_t;

    // Register set: index 0 is R1, index 7 is R8.
    typedef logic [7:0][WORD_W-1:0] regset_t;

    // Key, IV and block keep the bus bit order: the highest index holds
    // the first word (K1, IV1, word 0).
    typedef logic [7:0][WORD_W-1:0]       key_t;
    typedef logic [3:0][WORD_W-1:0]       iv_t;
    typedef logic [WORDS-1:0][WORD_W-1:0] block_t;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_INIT,
        ST_ENC,
        ST_DONE
    } state_e;

    typedef enum logic {
        MODE_INIT = 1'b0,
        MODE_ENC  = 1'b1
    } mode_e;

    // Added to R1 at the start of each initialization round.
    localparam word_t IV_CONST [INIT_ROUNDS] = '{16'h0000, 16'h0001, 16'h0002, 16'h0003};

    // R1..R4 = IV1..IV4 and R5..R8 = IV1..IV4.
    function automatic regset_t expand_iv(iv_t iv);
        regset_t r;
        for (int i = 0; i < 4; i++) begin
            r[i]   = iv[3-i];
            r[i+4] = iv[3-i];
        end
        return r;
    endfunction

endpackage

// File: rtl/hummingbird_ctrl_if.sv
// -----------------------------------------------------------------------------
// hummingbird_ctrl_if
// Request/response bundle of the Hummingbird-2 controller.
//   start, chain      : request and chained-continuation flag
//   key, iv, pt       : operands captured on an accepted start
//   busy, done        : in-progress flag and one-cycle completion pulse
//   ct                : ciphertext, valid from done until the next accepted start
//   state_valid       : an initialization has completed since reset
// master = requester, slave = controller.
// -----------------------------------------------------------------------------
interface hummingbird_ctrl_if;

    logic            start;
    logic            chain;
    hb2_pkg::key_t   key;
    hb2_pkg::iv_t    iv;
    hb2_pkg::block_t pt;
    logic            busy;
    logic            done;
    hb2_pkg::block_t ct;
    logic            state_valid;

    modport master (
        output start, chain, key, iv, pt,
        input  busy, done, ct, state_valid
    );

    modport slave (
        input  start, chain, key, iv, pt,
        output busy, done, ct, state_valid
    );

endinterface

// File: rtl/hb2_word_step.sv
// -----------------------------------------------------------------------------
// hb2_word_step
// One combinational Hummingbird-2 step on the shared 16-bit datapath.
//   mode_i   : MODE_INIT (one IV round) or MODE_ENC (one word encryption)
//   round_i  : initialization round index (selects the IV-round constant)
//   data_i   : plaintext word (ENC only)
//   key_i    : 128-bit key
//   r_i      : current R1..R8
//   result_o : ciphertext word (ENC only, 0 in INIT)
//   r_o      : next R1..R8
// All additions wrap modulo 2^16.
// -----------------------------------------------------------------------------
module hb2_word_step
    import hb2_pkg::*;
(
    input  mode_e            mode_i,
    input  logic [RND_W-1:0] round_i,
    input  word_t            data_i,
    input  key_t             key_i,
    input  regset_t          r_i,
    output word_t            result_o,
    output regset_t          r_o
);

    // Four 4-bit S-boxes; entry [i] substitutes nibble i (0 = least significant).
    localparam logic [3:0] SBOX [4][16] = '{
        '{4'h7, 4'hC, 4'hE, 4'h9, 4'h2, 4'h1, 4'h5, 4'hF, 4'hB, 4'h6, 4'hD, 4'h0, 4'h4, 4'h8, 4'hA, 4'h3},
        '{4'h4, 4'hA, 4'h1, 4'h6, 4'h8, 4'hF, 4'h7, 4'hC, 4'h3, 4'h0, 4'hE, 4'hD, 4'h5, 4'h9, 4'hB, 4'h2},
        '{4'h2, 4'hF, 4'hC, 4'h1, 4'h5, 4'h6, 4'hA, 4'hD, 4'hE, 4'h8, 4'h3, 4'h4, 4'h0, 4'hB, 4'h9, 4'h7},
        '{4'hF, 4'h4, 4'h5, 4'h8, 4'h9, 4'h7, 4'h2, 4'h1, 4'hA, 4'h3, 4'h0, 4'hE, 4'h6, 4'hC, 4'hD, 4'hB}
    };

    function automatic word_t rotl(word_t x, int unsigned n);
        return (x << n) | (x >> (WORD_W - n));
    endfunction

    // Nibble substitution followed by the linear mix x ^ (x<<<6) ^ (x<<<10).
    function automatic word_t f16(word_t x);
        word_t s;
        for (int i = 0; i < 4; i++) begin
            s[4*i +: 4] = SBOX[i][x[4*i +: 4]];
        end
        return s ^ rotl(s, 6) ^ rotl(s, 10);
    endfunction

    function automatic word_t wd16(word_t x, word_t a, word_t b, word_t c, word_t d);
        return f16(f16(f16(f16(x ^ a) ^ b) ^ c) ^ d);
    endfunction

    word_t k [8];   // k[0] = K1
    word_t t1, t2, t3, t4;

    always_comb begin
        for (int i = 0; i < 8; i++) begin
            k[i] = key_i[7-i];
        end
    end

    always_comb begin
        // NOTE: every output and temporary gets a default before the mode
        // branches, so no path leaves a value held and no latch is inferred.
        t1       = '0;
        t2       = '0;
        t3       = '0;
        t4       = '0;
        result_o = '0;
        r_o      = r_i;
        if (mode_i == MODE_INIT) begin
            t1 = wd16(r_i[0] + IV_CONST[round_i], k[0], k[1], k[2], k[3]);
            t2 = wd16(r_i[1] + t1, k[4], k[5], k[6], k[7]);
            t3 = wd16(r_i[2] + t2, k[0], k[1], k[2], k[3]);
            t4 = wd16(r_i[3] + t3, k[4], k[5], k[6], k[7]);
            r_o[0] = rotl(r_i[0] + t4, 3);
            r_o[1] = rotl(r_i[1] + t1, 1);
            r_o[2] = rotl(r_i[2] + t2, 8);
            r_o[3] = rotl(r_i[3] + t3, 1);
        end else begin
            t1 = wd16(r_i[0] + data_i, k[0], k[1], k[2], k[3]);
            t2 = wd16(r_i[1] + t1, k[4] ^ r_i[4], k[5] ^ r_i[5], k[6] ^ r_i[6], k[7] ^ r_i[7]);
            t3 = wd16(r_i[2] + t2, k[0] ^ r_i[4], k[1] ^ r_i[5], k[2] ^ r_i[6], k[3] ^ r_i[7]);
            result_o = wd16(r_i[3] + t3, k[4], k[5], k[6], k[7]) + r_i[0];
            r_o[0] = r_i[0] + t3;
            r_o[1] = r_i[1] + t1;
            r_o[2] = r_i[2] + t2;
            r_o[3] = r_i[3] + r_o[0] + t1;
        end
        // R5..R8 absorb the freshly updated R1..R4 in both modes.
        for (int i = 0; i < 4; i++) begin
            r_o[i+4] = r_i[i+4] ^ r_o[i];
        end
    end

endmodule

// File: rtl/hummingbird_ctrl.sv
// -----------------------------------------------------------------------------
// hummingbird_ctrl
// Iterative Hummingbird-2 block controller: four IV rounds then eight word
// encryptions on one shared hb2_word_step instance.
//   clk : rising-edge clock
//   rst : asynchronous active-low reset
//   bus : hummingbird_ctrl_if.slave (start/chain/key/iv/pt in,
//         busy/done/ct/state_valid out)
// A chained request with state_valid set skips initialization and continues
// from the held R1..R8.
// -----------------------------------------------------------------------------
module hummingbird_ctrl
    import hb2_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    hummingbird_ctrl_if.slave bus
);

    state_e           state_q;
    logic [CNT_W-1:0] cnt_q;
    key_t             key_q;
    iv_t              iv_q;
    block_t           pt_q;
    block_t           ct_q;
    regset_t          r_q;
    logic             busy_q;
    logic             done_q;
    logic             valid_q;

    mode_e            step_mode;
    regset_t          step_r_in;
    word_t            step_data;
    logic [CNT_W-1:0] word_idx;
    regset_t          r_d;
    word_t            word_d;

    always_comb begin
        // Word 0 sits in the top slice of the block.
        word_idx  = CNT_W'(WORDS - 1) - cnt_q;
        step_mode = (state_q == ST_ENC) ? MODE_ENC : MODE_INIT;
        // The first IV round starts from the expanded captured IV.
        step_r_in = (state_q == ST_INIT && cnt_q == '0) ? expand_iv(iv_q) : r_q;
        step_data = pt_q[word_idx];
    end

    hb2_word_step u_step (
        .mode_i   (step_mode),
        .round_i  (cnt_q[RND_W-1:0]),
        .data_i   (step_data),
        .key_i    (key_q),
        .r_i      (step_r_in),
        .result_o (word_d),
        .r_o      (r_d)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            // NOTE: the captured operands and R1..R8 are reset along with the
            // control state, so a mid-block reset leaves no residue behind.
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            key_q   <= '0;
            iv_q    <= '0;
            pt_q    <= '0;
            ct_q    <= '0;
            r_q     <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            valid_q <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments throughout, so every register
            // samples pre-edge values regardless of statement order.
            done_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (bus.start) begin
                        key_q  <= bus.key;
                        pt_q   <= bus.pt;
                        cnt_q  <= '0;
                        busy_q <= 1'b1;
                        if (bus.chain && valid_q) begin
                            state_q <= ST_ENC;
                        end else begin
                            iv_q    <= bus.iv;
                            state_q <= ST_INIT;
                        end
                    end
                end
                ST_INIT: begin
                    r_q <= r_d;
                    if (cnt_q == CNT_W'(INIT_ROUNDS - 1)) begin
                        valid_q <= 1'b1;
                        cnt_q   <= '0;
                        state_q <= ST_ENC;
                    end else begin
                        cnt_q <= cnt_q + CNT_W'(1);
                    end
                end
                ST_ENC: begin
                    r_q            <= r_d;
                    ct_q[word_idx] <= word_d;
                    cnt_q          <= cnt_q + CNT_W'(1);   // wraps to 0 after word 7
                    if (cnt_q == CNT_W'(WORDS - 1)) begin
                        done_q  <= 1'b1;
                        state_q <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    busy_q  <= 1'b0;
                    state_q <= ST_IDLE;
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign bus.busy        = busy_q;
    assign bus.done        = done_q;
    assign bus.ct          = ct_q;
    assign bus.state_valid = valid_q;

endmodule
